// File: rtl/ccg_lut_eval_pipe_pkg.sv
// Shared types and helpers for the programmable LUT evaluator.
// CCG_LUT_PARITY_EN (see top) selects the per-row parity option.
package ccg_lut_eval_pipe_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } ccg_state_e;

  function automatic int ccg_depth(input int n);
    return 1 << n;
  endfunction

  // Even parity over a zero-extended row; a stored row including its parity bit folds to 0.
  function automatic logic ccg_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ccg_lut_eval_pipe_if.sv
// Config and streaming signals of the LUT evaluator.
// The master drives config and vectors; the slave is the evaluator itself.
interface ccg_lut_eval_pipe_if #(
  parameter int NUM_IN  = 5,
  parameter int NUM_OUT = 17
);
  logic               cfg_clear;
  logic               cfg_we;
  logic [NUM_IN-1:0]  cfg_addr;
  logic [NUM_OUT-1:0] cfg_data;
  logic               cfg_done;
  logic               cfg_err;
  logic               run;
  logic               in_valid;
  logic               in_ready;
  logic [NUM_IN-1:0]  in_x;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_f;
  logic               par_err;

  modport master (
    output cfg_clear, cfg_we, cfg_addr, cfg_data, cfg_done,
    output in_valid, in_x, out_ready,
    input  cfg_err, run, in_ready, out_valid, out_f, par_err
  );

  modport slave (
    input  cfg_clear, cfg_we, cfg_addr, cfg_data, cfg_done,
    input  in_valid, in_x, out_ready,
    output cfg_err, run, in_ready, out_valid, out_f, par_err
  );
endinterface

// File: rtl/ccg_lut_eval_pipe_pipe_stage.sv
// One valid/ready register slice; data only updates on a valid load so it holds
// its last value while empty.
module ccg_lut_eval_pipe_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load_en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load_en) begin
      valid <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/ccg_lut_eval_pipe.sv
// Table-loaded NUM_IN -> NUM_OUT function evaluator with a 2-stage stream pipeline.
// Define CCG_LUT_PARITY_EN to store and check an even-parity bit per row.
//
//   state | meaning
//   LOAD  | rows written via cfg_we, pipeline closed (in_ready=0)
//   RUN   | table frozen, vectors stream through S1 (x) and S2 (table[x])
module ccg_lut_eval_pipe
  import ccg_lut_eval_pipe_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int NUM_OUT = 17
) (
  input logic clk,
  input logic rst,
  ccg_lut_eval_pipe_if.slave bus
);

  localparam int DEPTH = ccg_depth(NUM_IN);
`ifdef CCG_LUT_PARITY_EN
  localparam int ROW_W = NUM_OUT + 1;
`else
  localparam int ROW_W = NUM_OUT;
`endif

  ccg_state_e         state_q;
  logic [DEPTH-1:0]   map_q;
  logic [DEPTH-1:0]   map_upd;
  logic               cfg_err_q;
  logic [ROW_W-1:0]   table_q [DEPTH];
  logic [ROW_W-1:0]   wr_row;
  logic [ROW_W-1:0]   rd_row;
  logic [NUM_OUT-1:0] rd_f;

  logic               s1_v;
  logic               s2_v;
  logic               s1_load;
  logic               s2_load;
  logic               s1_in_v;
  logic [NUM_IN-1:0]  s1_x;
  logic [NUM_OUT-1:0] s2_f;

  // Done must see a row written in the same cycle.
  always_comb begin
    map_upd = map_q;
    if (bus.cfg_we) map_upd[bus.cfg_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      map_q     <= '0;
      cfg_err_q <= 1'b0;
    end else if (bus.cfg_clear) begin
      state_q <= LOAD;
      map_q   <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          map_q <= map_upd;
          if (bus.cfg_done) begin
            if (&map_upd) state_q   <= RUN;
            else          cfg_err_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.cfg_we) cfg_err_q <= 1'b1;
        end
        default: state_q <= LOAD;
      endcase
    end
  end

`ifdef CCG_LUT_PARITY_EN
  assign wr_row = {ccg_par(64'(bus.cfg_data)), bus.cfg_data};
`else
  assign wr_row = bus.cfg_data;
`endif

  // Contents are don't-care until written, so the table carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && bus.cfg_we && !bus.cfg_clear)
      table_q[bus.cfg_addr] <= wr_row;
  end

  assign rd_row = table_q[s1_x];
  assign rd_f   = rd_row[NUM_OUT-1:0];

  assign s2_load      = ~s2_v | bus.out_ready;
  assign s1_load      = ~s1_v | s2_load;
  assign bus.in_ready = (state_q == RUN) & s1_load;
  assign s1_in_v      = bus.in_valid & bus.in_ready;

  ccg_lut_eval_pipe_pipe_stage #(.W(NUM_IN)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.cfg_clear),
    .load_en  (s1_load),
    .in_valid (s1_in_v),
    .in_data  (bus.in_x),
    .valid    (s1_v),
    .data     (s1_x)
  );

  ccg_lut_eval_pipe_pipe_stage #(.W(NUM_OUT)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.cfg_clear),
    .load_en  (s2_load),
    .in_valid (s1_v),
    .in_data  (rd_f),
    .valid    (s2_v),
    .data     (s2_f)
  );

`ifdef CCG_LUT_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par_err_q <= 1'b0;
    else if (!bus.cfg_clear && s1_v && s2_load && ccg_par(64'(rd_row)))
      par_err_q <= 1'b1;
  end

  assign bus.par_err = par_err_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.run       = (state_q == RUN);
  assign bus.cfg_err   = cfg_err_q;
  assign bus.out_valid = s2_v;
  assign bus.out_f     = s2_f;

endmodule

// File: tb/tb_ccg_lut_eval_pipe.sv
// Self-checking bench for ccg_lut_eval_pipe: vector table plus scoreboard queue.
module tb_ccg_lut_eval_pipe;

  typedef struct {
    logic [4:0]  x;
    logic [16:0] f;
  } vec_t;

  logic clk;
  logic rst;

  ccg_lut_eval_pipe_if #(.NUM_IN(5), .NUM_OUT(17)) bus ();

  ccg_lut_eval_pipe #(.NUM_IN(5), .NUM_OUT(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int emit_cnt = 0;
  logic last_acc = 1'b0;
  logic chk_rdy = 1'b0;
  logic chk_lat = 1'b0;
  logic hold_chk = 1'b0;
  logic [16:0] held_f = '0;

  vec_t        vecs [32];
  logic [16:0] exp_tab [32];
  logic [16:0] exp_q [$];
  int          stamp_q [$];

  function automatic logic [16:0] model_f(input logic [4:0] x);
    logic [16:0] f;
    f = '0;
    f[6]  = ~(x[0] ^ x[1]);
    f[9]  = ~(x[2] ^ x[4]);
    f[11] = x[4];
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic step();
    logic acc;
    logic emit;
    logic [16:0] e;
    int st;
    #1;
    acc  = bus.in_valid & bus.in_ready;
    emit = bus.out_valid & bus.out_ready;
    if (chk_rdy) check("in_ready_stream", 64'(bus.in_ready), 64'd1);
    if (hold_chk && bus.out_valid) check("out_f_stable", 64'(bus.out_f), 64'(held_f));
    if (emit) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected none", bus.out_f);
      end else begin
        e  = exp_q.pop_front();
        st = stamp_q.pop_front();
        check("out_f", 64'(bus.out_f), 64'(e));
        if (chk_lat) check("latency", 64'(cyc - st), 64'd2);
        emit_cnt++;
      end
    end
    if (acc) begin
      exp_q.push_back(exp_tab[bus.in_x]);
      stamp_q.push_back(cyc);
      acc_cnt++;
    end
    last_acc = acc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic stream(input int first, input int n);
    int idx;
    int budget;
    logic [4:0] x;
    idx = 0;
    budget = 0;
    x = 5'(first);
    bus.in_valid = 1'b1;
    bus.in_x = x;
    while (idx < n && budget < 4 * n + 20) begin
      step();
      budget++;
      if (last_acc) begin
        idx++;
        x = x + 5'd1;
        bus.in_x = x;
      end
    end
    bus.in_valid = 1'b0;
    check("stream_accepts", 64'(idx), 64'(n));
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load(input int skip);
    for (int r = 0; r < 32; r++) begin
      if (r != skip) begin
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 5'(r);
        bus.cfg_data = exp_tab[r];
        step();
      end
    end
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_done();
    bus.cfg_done = 1'b1;
    step();
    bus.cfg_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int e0;
    logic [4:0] x;

    for (int i = 0; i < 32; i++) begin
      vecs[i].x  = 5'(i);
      vecs[i].f  = model_f(5'(i));
      exp_tab[i] = vecs[i].f;
    end

    rst = 1'b1;
    bus.cfg_clear = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.cfg_done = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    check("rst_run", 64'(bus.run), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_f", 64'(bus.out_f), 64'd0);
    check("rst_par_err", 64'(bus.par_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full load, closed pipeline in LOAD, then RUN
    load(-1);
    bus.in_valid = 1'b1;
    #1;
    check("in_ready_load", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    pulse_done();
    check("run_after_done", 64'(bus.run), 64'd1);
    check("cfg_err_clean", 64'(bus.cfg_err), 64'd0);

    // Full-throughput stream of every row
    e0 = emit_cnt;
    chk_rdy = 1'b1;
    chk_lat = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x = vecs[i].x;
      step();
      check("accept", 64'(last_acc), 64'd1);
    end
    chk_rdy = 1'b0;
    drain();
    chk_lat = 1'b0;
    check("stream_count", 64'(emit_cnt - e0), 64'd32);

    // Backpressure: 6 stalled cycles capture exactly two vectors
    e0 = emit_cnt;
    a0 = acc_cnt;
    bus.out_ready = 1'b0;
    x = 5'd10;
    bus.in_valid = 1'b1;
    bus.in_x = x;
    hold_chk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_acc) begin
        x = x + 5'd1;
        bus.in_x = x;
      end
      if (bus.out_valid && !hold_chk) begin
        held_f = bus.out_f;
        hold_chk = 1'b1;
      end
    end
    #1;
    check("bp_accepts", 64'(acc_cnt - a0), 64'd2);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check("bp_out_f", 64'(bus.out_f), 64'(exp_tab[10]));
    hold_chk = 1'b0;
    bus.out_ready = 1'b1;
    stream(12, 4);
    drain();
    check("bp_count", 64'(emit_cnt - e0), 64'd6);

    // Write in RUN is ignored and flagged
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 5'd0;
    bus.cfg_data = 17'h1ffff;
    step();
    bus.cfg_we = 1'b0;
    check("run_we_err", 64'(bus.cfg_err), 64'd1);
    check("run_we_run", 64'(bus.run), 64'd1);
    stream(0, 1);
    drain();

    // Clear with two results in flight
    bus.out_ready = 1'b0;
    stream(20, 2);
    bus.cfg_clear = 1'b1;
    step();
    bus.cfg_clear = 1'b0;
    #1;
    check("clr_out_valid", 64'(bus.out_valid), 64'd0);
    check("clr_run", 64'(bus.run), 64'd0);
    check("clr_in_ready", 64'(bus.in_ready), 64'd0);
    check("clr_cfg_err", 64'(bus.cfg_err), 64'd1);
    exp_q.delete();
    stamp_q.delete();
    bus.out_ready = 1'b1;

    // Clear outranks done; map is gone afterwards
    load(-1);
    bus.cfg_clear = 1'b1;
    bus.cfg_done = 1'b1;
    step();
    bus.cfg_clear = 1'b0;
    bus.cfg_done = 1'b0;
    check("clr_prio_run", 64'(bus.run), 64'd0);
    pulse_done();
    check("done_after_clr", 64'(bus.run), 64'd0);

    // Asynchronous reset mid-stream
    load(-1);
    pulse_done();
    check("run_reload", 64'(bus.run), 64'd1);
    stream(0, 4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_run", 64'(bus.run), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd0);
    exp_q.delete();
    stamp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_cfg_err", 64'(bus.cfg_err), 64'd0);

    // Missing row 5; then row 5 written together with done
    load(5);
    pulse_done();
    check("miss_cfg_err", 64'(bus.cfg_err), 64'd1);
    check("miss_run", 64'(bus.run), 64'd0);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 5'd5;
    bus.cfg_data = exp_tab[5];
    bus.cfg_done = 1'b1;
    step();
    bus.cfg_we = 1'b0;
    bus.cfg_done = 1'b0;
    check("fix_run", 64'(bus.run), 64'd1);

    // Corrupted row 3
`ifdef CCG_LUT_PARITY_EN
    dut.table_q[3][0] = ~dut.table_q[3][0];
    exp_tab[3] = exp_tab[3] ^ 17'h1;
`endif
    stream(3, 1);
    drain();
`ifdef CCG_LUT_PARITY_EN
    check("par_err", 64'(bus.par_err), 64'd1);
`else
    check("par_err", 64'(bus.par_err), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
